// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the IF-stage fetch controller.
// Imported by fetch_ctrl; the PC register lives beside it at IF-stage level.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    KILL,
    EXC
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK       = 32'h0000_0003;

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing, single-outstanding imem handshake, one-entry IF slot.
// FETCH_MISALIGN_EXC_EN: misaligned PCs load a fault into the slot instead of being masked.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_exc
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;

  logic        w_free;
  logic        w_redir;
  logic        w_req;
  logic        w_load;
  logic        w_misal;
  logic        w_trap;
  logic [31:0] w_fetch_addr;
  logic [31:0] w_redir_tgt;

`ifdef FETCH_MISALIGN_EXC_EN
  assign w_misal      = |(pc & ALIGN_MASK);
  assign w_fetch_addr = pc;
  assign w_redir_tgt  = redirect_pc;
`else
  assign w_misal      = 1'b0;
  assign w_fetch_addr = pc & ~ALIGN_MASK;
  assign w_redir_tgt  = redirect_pc & ~ALIGN_MASK;
`endif

  assign w_free  = !r_if_valid || !stall;
  assign w_redir = !reset && redirect_valid
                && (r_state != IDLE);
  assign w_req   = !reset && (r_state == REQ)
                && w_free && !redirect_valid
                && !w_misal;
  assign w_load  = !reset && (r_state == WAIT)
                && imem_rvalid && !w_redir;
  assign w_trap  = !reset && (r_state == REQ)
                && w_free && w_misal && !w_redir;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        if (w_redir)
          w_state_nxt = REQ;
        else if (w_trap)
          w_state_nxt = EXC;
        else if (w_req && imem_gnt)
          w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_redir)
          w_state_nxt = imem_rvalid ? REQ : KILL;
        else if (imem_rvalid)
          w_state_nxt = REQ;
      end
      // the killed response still has to drain before refetching
      KILL: begin
        if (imem_rvalid)
          w_state_nxt = REQ;
      end
      EXC: begin
        if (w_redir)
          w_state_nxt = REQ;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = w_req;
    imem_addr = reset ? '0 : w_fetch_addr;
    pc_en     = w_redir || w_load;
    pc_next   = '0;
    unique case (1'b1)
      w_redir: pc_next = w_redir_tgt;
      w_load:  pc_next = pc + 32'(INSTR_BYTES);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= '0;
    end else if (w_redir) begin
      r_if_valid <= 1'b0;
    end else if (w_load) begin
      r_if_valid <= 1'b1;
      r_if_pc    <= pc;
      r_if_instr <= imem_rdata;
    end else if (w_trap) begin
      r_if_valid <= 1'b1;
      r_if_pc    <= pc;
      r_if_instr <= '0;
    end else if (!stall) begin
      r_if_valid <= 1'b0;
    end
  end

`ifdef FETCH_MISALIGN_EXC_EN
  logic r_if_exc;

  always_ff @(posedge clk) begin
    if (reset || w_redir || w_load) begin
      r_if_exc <= 1'b0;
    end else if (w_trap) begin
      r_if_exc <= 1'b1;
    end
  end

  assign if_exc = r_if_exc;
`else
  assign if_exc = 1'b0;
`endif

  assign if_valid = r_if_valid;
  assign if_pc    = r_if_pc;
  assign if_instr = r_if_instr;

  // the external PC register must come out of reset at the boot address
  a_boot_pc: assert property (
    @(posedge clk) $fell(reset) |-> (pc == RESET_PC)
  );

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch controller for the pipelined RISC-V core. Sequences the program counter register by driving its `pc_next`/`pc_en` inputs, runs a single-outstanding request/grant/response handshake with instruction memory, and hands fetched instructions to decode through a one-entry output slot. Redirects (branch/jump/trap) from later stages override sequential fetch and kill any in-flight response.

## Interface
- `RESET_PC`, default 32'h0000_0000: boot address. Must equal the PC register's reset value; the controller does not load it.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `pc` in 32: current PC from the PC register.
- `pc_next` out 32: next PC value to the PC register.
- `pc_en` out 1: PC register load enable.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out 32: fetch address.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid. Exactly one response per grant, no earlier than one cycle after the grant.
- `imem_rdata` in 32: instruction word.
- `redirect_valid` in 1: redirect request from EX/trap logic.
- `redirect_pc` in 32: redirect target.
- `stall` in 1: decode cannot accept the slot this cycle.
- `if_valid` out 1: output slot holds an instruction.
- `if_pc` out 32: PC of the slot instruction.
- `if_instr` out 32: slot instruction.
- `if_exc` out 1: slot holds an instruction-address-misaligned fault.

## Operation
- States: IDLE, REQ, WAIT, KILL, EXC.
- Reset (any state, mid-transaction included): state IDLE; `if_valid`, `if_exc` = 0; `if_pc`, `if_instr` = 0. Combinational outputs are 0 during reset. Any later `imem_rvalid` is ignored unless the state is WAIT or KILL.
- IDLE: no request. Goes to REQ unconditionally on the next cycle.
- Slot free: `!if_valid || !stall`.
- REQ:
  - `imem_req` = slot free && !`redirect_valid`; `imem_addr` = `pc`.
  - Once asserted, `imem_req` stays asserted with a stable address until grant or redirect.
  - On `imem_req && imem_gnt`, go to WAIT.
- WAIT: on `imem_rvalid`:
  - Load the slot: `if_valid`=1, `if_pc`=`pc`, `if_instr`=`imem_rdata`, `if_exc`=0.
  - `pc_en`=1, `pc_next`=`pc`+4 (mod 2^32, wraps FFFF_FFFC→0000_0000).
  - Go to REQ.
- Slot consumption: a valid slot with `stall`=0 is consumed at the clock edge. `if_valid` falls unless reloaded in the same cycle. While `stall`=1 the slot holds all fields.
- Redirect (highest priority, any state except IDLE):
  - `pc_en`=1, `pc_next`=`redirect_pc`; the slot is flushed (`if_valid`=0, `if_exc`=0).
  - From REQ or EXC: go to REQ.
  - From WAIT with `imem_rvalid`=0: go to KILL.
  - From WAIT with `imem_rvalid`=1: discard the response and go to REQ.
  - From KILL: stay in KILL.
- KILL: no request. On `imem_rvalid`, discard the response and go to REQ.
- Redirect + stall in the same cycle: redirect wins and the slot is flushed.

## Timing
- First `imem_req` is asserted 2 cycles after `reset` deasserts (IDLE, then REQ).
- With a same-cycle grant and a next-cycle response: `if_valid` rises 2 cycles after the request. Sustained throughput is 1 instruction per 2 cycles.
- `pc_en` is a single-cycle pulse per response or redirect. `pc` reflects the new value one cycle later.
- Redirect-to-first-request latency: 1 cycle in REQ/EXC; 1 cycle after the killed response arrives when in WAIT/KILL.

## Configuration
- `FETCH_MISALIGN_EXC_EN` defined:
  - In REQ, if `pc[1:0]`≠0 and the slot is free: no request.
  - Slot loads `if_valid`=1, `if_exc`=1, `if_pc`=`pc`, `if_instr`=0; state goes to EXC.
  - EXC issues no requests and leaves only on redirect.
- Not defined:
  - `if_exc` is tied 0 and the EXC state is unreachable.
  - `imem_addr` = {`pc[31:2]`, 2'b00}.
  - Redirect `pc_next` = {`redirect_pc[31:2]`, 2'b00}.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum (IDLE, REQ, WAIT, KILL, EXC).
  - `INSTR_BYTES` = 4.
  - `RESET_PC_DEFAULT`.
- No sub-module. The PC register is instantiated beside `fetch_ctrl` at the IF-stage level, not inside it.

## Test plan
- Reset release, `imem_gnt`=1 always, `rvalid` one cycle after each grant, `rdata`=addr+1 → `imem_addr` sequence 0, 4, 8; `if_instr` 1, 5, 9; `pc_en` pulses every 2 cycles.
- `stall`=1 for 5 cycles with a full slot → no `imem_req`, slot fields unchanged. Release → consumed, next request on the following cycle.
- Redirect to 0x100 in WAIT, `rvalid` 3 cycles later with 0xDEAD → response dropped, `if_valid` stays 0, next `imem_addr`=0x100.
- Redirect to 0x200 in the same cycle as `rvalid` and `stall` → slot flushed, state REQ, next `imem_addr`=0x200.
- `pc`=FFFF_FFFC fetch → `pc_next`=0000_0000.
- With the macro, redirect to 0x102 → `if_valid`=1, `if_exc`=1, `if_pc`=0x102, no `imem_req` until a redirect to 0x104. Without the macro → `imem_addr`=0x100.
